regfile_arbiter: RTL and testbench

Round-robin arbiter and access sequencer that shares the single register-file port among several requesters (for example decode, ALU writeback and debug). It sits directly in front of the register file: it collects request/select/data bundles, grants one requester at a time, drives the register file's select/write-enable/write-data lines for exactly one cycle, and returns a registered read value with a one-cycle acknowledge pulse.

---
 rtl/rf_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 36 +++
 rtl/regfile_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file port arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SEL_W  = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first unmasked request at or after ptr_i,
// wrapping modulo NUM_REQ. Returns the winner one-hot and as an index.
module rr_picker
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  logic [NUM_REQ-1:0] cand;
  logic               found;

  always_comb begin
    cand      = req_i & ~mask_i;
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && cand[j]) begin
        found       = 1'b1;
        win_oh_o[j] = 1'b1;
        win_idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer in front of a single register-file port.
// Optional grant locking is built when RF_ARB_LOCK_EN is defined.
module regfile_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int MAX_LOCK = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef RF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [SEL_W-1:0]          rf_sel,
  output logic                      rf_we,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [DATA_W-1:0]         rf_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || MAX_LOCK < 1) begin : g_bad_cfg
    $error("regfile_arbiter: NUM_REQ must be >= 2 and MAX_LOCK >= 1");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                cmd_we_q, cmd_we_d;
  logic [SEL_W-1:0]    cmd_sel_q, cmd_sel_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  win_oh, pick_mask, pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any, regrant, load;

  assign win_oh    = NUM_REQ'(1) << win_q;
  // The requester being acknowledged must not win again at the RESP edge.
  assign pick_mask = (state_q == RESP) ? win_oh : '0;
  assign pick_any  = |pick_oh;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (req),
    .mask_i    (pick_mask),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx)
  );

`ifdef RF_ARB_LOCK_EN
  localparam int LCK_W = $clog2(MAX_LOCK + 1);
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;

  assign regrant = (state_q == RESP) && req_lock[win_q] && req[win_q] &&
                   (lock_cnt_q < LCK_W'(MAX_LOCK - 1));

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == RESP) lock_cnt_d = regrant ? lock_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_cnt_q <= '0;
    else       lock_cnt_q <= lock_cnt_d;
  end
`else
  assign regrant = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    cmd_we_d    = cmd_we_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_wdata_d = cmd_wdata_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d       = cmd_we_q ? cmd_wdata_q : rf_rdata;
        ack_d[win_q]  = 1'b1;
        ptr_d         = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (regrant) begin
          load    = 1'b1;
          state_d = ACCESS;
        end else if (pick_any) begin
          win_d   = pick_idx;
          load    = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cmd_we_d    = req_we[win_d];
      cmd_sel_d   = req_sel[int'(win_d)*SEL_W +: SEL_W];
      cmd_wdata_d = req_wdata[int'(win_d)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      ptr_q       <= '0;
      cmd_we_q    <= 1'b0;
      cmd_sel_q   <= '0;
      cmd_wdata_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      cmd_we_q    <= cmd_we_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  // Strobe and grant are decoded from state so reset removes them at once.
  assign gnt      = (state_q == ACCESS) ? win_oh : '0;
  assign rf_we    = (state_q == ACCESS) && cmd_we_q;
  assign rf_sel   = cmd_sel_q;
  assign rf_wdata = cmd_wdata_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized self-checking bench for regfile_arbiter with a transaction-level
// round-robin model and a behavioural register file behind the port.
module tb_regfile_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int SW = 3;
  localparam int NR = 1 << SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_we;
  logic [N*SW-1:0] req_sel;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, ack;
  logic [DW-1:0] rdata, rf_wdata, rf_rdata;
  logic          busy, rf_we;
  logic [SW-1:0] rf_sel;
`ifdef RF_ARB_LOCK_EN
  logic [N-1:0]  req_lock;
`endif

  logic          c_we [N];
  logic [SW-1:0] c_sel [N];
  logic [DW-1:0] c_wd [N];

  logic [DW-1:0] rf_mem [NR];
  logic          ld_en;
  logic [SW-1:0] ld_sel;
  logic [DW-1:0] ld_data;

  int n_tests, n_fail;
  int cyc, last_g, last_w, ptr;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] exp_rf [NR];
  logic          lw_we;
  logic [SW-1:0] lw_sel;
  logic [DW-1:0] lw_wd;
  int gq[$];
  int gcyc[$];

  always #5 clk = ~clk;

  regfile_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
`ifdef RF_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .rf_sel    (rf_sel),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  always_comb begin
    req_we    = '0;
    req_sel   = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_we[i]              = c_we[i];
      req_sel[i*SW +: SW]    = c_sel[i];
      req_wdata[i*DW +: DW]  = c_wd[i];
    end
  end

  assign rf_rdata = rf_mem[rf_sel];
  always @(posedge clk) begin
    if (rf_we)      rf_mem[rf_sel] <= rf_wdata;
    else if (ld_en) rf_mem[ld_sel] <= ld_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    last_g = -10;
    last_w = 0;
    ptr    = 0;
  endtask

  // One clock of observation: outputs sampled at negedge, predicted from the
  // request set seen at the preceding posedge and the round-robin rules.
  task automatic step();
    logic [N-1:0] cand, eg, eack;
    int w;
    @(negedge clk);
    cyc++;
    eg = '0; eack = '0; cand = '0; w = -1;
    if (cyc == last_g + 1) begin
      eack[last_w] = 1'b1;
      if (lw_we) exp_rf[lw_sel] = lw_wd;
    end else if (!reset) begin
      cand = req;
      if (cyc == last_g + 2) cand[last_w] = 1'b0;
      for (int k = 0; k < N; k++)
        if (w < 0 && cand[(ptr + k) % N]) w = (ptr + k) % N;
    end
    if (w >= 0) eg[w] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    check("ack", 32'(ack), 32'(eack));
    check("busy", 32'(busy), 32'((w >= 0) || (eack != '0)));
    check("rf_we", 32'(rf_we), 32'((w >= 0) ? c_we[w] : 1'b0));
    if (w >= 0) begin
      check("rf_sel", 32'(rf_sel), 32'(c_sel[w]));
      if (c_we[w]) check("rf_wdata", 32'(rf_wdata), 32'(c_wd[w]));
      exp_rdata = c_we[w] ? c_wd[w] : exp_rf[c_sel[w]];
      lw_we  = c_we[w];
      lw_sel = c_sel[w];
      lw_wd  = c_wd[w];
      last_g = cyc;
      last_w = w;
      ptr    = (w + 1) % N;
      gq.push_back(w);
      gcyc.push_back(cyc);
    end
    if (eack != '0) check("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  // Requesters drop on ack; idle ones raise a new random command with pct% chance.
  task automatic drive(input int pct);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) req[i] = 1'b0;
      else if (!req[i] && pct > 0 && int'($urandom_range(99, 0)) < pct) begin
        req[i]   = 1'b1;
        c_we[i]  = 1'($urandom_range(1, 0));
        c_sel[i] = SW'($urandom_range(NR - 1, 0));
        c_wd[i]  = DW'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; req = '0; ld_en = 1'b0; ld_sel = '0; ld_data = '0;
    lw_we = 1'b0; lw_sel = '0; lw_wd = '0; exp_rdata = '0;
`ifdef RF_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < N; i++) begin c_we[i] = 1'b0; c_sel[i] = '0; c_wd[i] = '0; end
    model_reset();
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_rf_sel", 32'(rf_sel), 0);
    check("rst_rf_wdata", 32'(rf_wdata), 0);

    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_sel = SW'(i);
      ld_data = (i == 5) ? 16'h1234 : DW'($urandom);
      exp_rf[i] = ld_data;
    end
    @(negedge clk);
    ld_en = 1'b0;
    reset = 1'b0;

    // single read
    c_we[1] = 1'b0; c_sel[1] = 3'd5; req[1] = 1'b1;
    step();
    check("rd_gnt", 32'(gnt), 32'h2);
    check("rd_sel", 32'(rf_sel), 5);
    drive(0);
    step();
    check("rd_ack", 32'(ack), 32'h2);
    check("rd_data", 32'(rdata), 32'h1234);
    drive(0);
    step(); drive(0);

    // single write
    c_we[0] = 1'b1; c_sel[0] = 3'd2; c_wd[0] = 16'hBEEF; req[0] = 1'b1;
    step();
    check("wr_we", 32'(rf_we), 1);
    check("wr_sel", 32'(rf_sel), 2);
    check("wr_wdata", 32'(rf_wdata), 32'hBEEF);
    drive(0);
    step();
    check("wr_we_once", 32'(rf_we), 0);
    check("wr_ack", 32'(ack), 32'h1);
    check("wr_rdata", 32'(rdata), 32'hBEEF);
    drive(0);
    step(); drive(0);

    // reset while requester 2 is in its access cycle
    c_we[2] = 1'b1; c_sel[2] = 3'd3; c_wd[2] = 16'hA5A5; req[2] = 1'b1;
    step();
    check("rm_gnt", 32'(gnt), 32'h4);
    #2 reset = 1'b1;
    #1;
    check("rm_rf_we", 32'(rf_we), 0);
    check("rm_gnt0", 32'(gnt), 0);
    check("rm_busy", 32'(busy), 0);
    req = '0;
    model_reset();
    step();
    check("rm_no_ack", 32'(ack), 0);
    step();
    reset = 1'b0;

    // full contention, first grant after reset must be requester 0
    gq.delete(); gcyc.delete();
    for (int i = 0; i < N; i++) begin
      c_we[i] = 1'($urandom_range(1, 0)); c_sel[i] = SW'($urandom_range(NR - 1, 0));
      c_wd[i] = DW'($urandom); req[i] = 1'b1;
    end
    for (int t = 0; t < 14; t++) begin step(); drive(100); end
    check("cont_count", 32'(gq.size() >= 6), 1);
    for (int i = 0; i < 6 && i < gq.size(); i++) check("cont_order", 32'(gq[i]), 32'(i % 3));
    for (int i = 1; i < 6 && i < gcyc.size(); i++) check("cont_gap", 32'(gcyc[i] - gcyc[i-1]), 2);
    for (int t = 0; t < 8; t++) begin step(); drive(0); end

    // requester drops during its access cycle
    c_we[1] = 1'b0; c_sel[1] = 3'd5; req[1] = 1'b1;
    step();
    check("drop_gnt", 32'(gnt), 32'h2);
    req[1] = 1'b0;
    step();
    check("drop_ack", 32'(ack), 32'h2);
    step();
    check("drop_no_regrant", 32'(gnt), 0);
    step();
    check("drop_no_regrant2", 32'(gnt), 0);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin step(); drive(35); end
    for (int t = 0; t < 10; t++) begin step(); drive(0); end

`ifdef RF_ARB_LOCK_EN
    // lock: requester 0 holds lock, requester 1 waits
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req = '0;
    c_we[0] = 1'b0; c_sel[0] = 3'd1; c_we[1] = 1'b0; c_sel[1] = 3'd4;
    req[0] = 1'b1; req_lock[0] = 1'b1; req[1] = 1'b1;
    gq.delete();
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
      if (ack[1]) req[1] = 1'b0;
    end
    check("lock_count", 32'(gq.size() >= 5), 1);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      check("lock_order", 32'(gq[i]), (i < 4) ? 0 : 1);
    req = '0; req_lock = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
